// File: rtl/s2p.sv
// s2p: serial-to-parallel deframer, LSB-first bits in, BUFFER_SIZE-bit words out through a one-deep valid/ready register
// Ports: i_clk/i_rst_n clock and async active-low reset; i_data/i_dv serial bit and its valid;
//   i_ready downstream accept; i_clr clears sticky flags; o_data/o_dv assembled word and valid;
//   o_abort sticky mid-frame i_dv drop; o_ovf sticky word lost to a full output; o_perr parity error of o_data.
// Define S2P_PARITY_EN to receive a trailing even-parity bit per frame and report mismatches on o_perr.
module s2p #(
  parameter int BUFFER_SIZE = 7
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_data,
  input  logic                   i_dv,
  input  logic                   i_ready,
  input  logic                   i_clr,
  output logic [BUFFER_SIZE-1:0] o_data,
  output logic                   o_dv,
  output logic                   o_abort,
  output logic                   o_ovf,
  output logic                   o_perr
);
`ifdef S2P_PARITY_EN
  localparam int FRAME_LEN = BUFFER_SIZE + 1;
`else
  localparam int FRAME_LEN = BUFFER_SIZE;
`endif
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic IDLE = 1'b0;
  localparam logic RECV = 1'b1;
  logic                   state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]   sr_q, sr_d;
  logic [BUFFER_SIZE-1:0] data_q, data_d;
  logic                   dv_q, dv_d, abort_q, abort_d, ovf_q, ovf_d;
  logic                   done, load;
  // The completed word is taken from sr_d so it reaches o_data on the same edge that captures the final bit.
  always_comb begin
    sr_d    = i_dv ? FRAME_LEN'({i_data, sr_q} >> 1) : sr_q;
    done    = i_dv && cnt_q == CW'(FRAME_LEN - 1);
    cnt_d   = (!i_dv || done) ? '0 : cnt_q + CW'(1);
    state_d = (!i_dv || done) ? IDLE : RECV;
    load    = done && (!dv_q || i_ready);
    dv_d    = load || (dv_q && !i_ready);
    data_d  = load ? sr_d[BUFFER_SIZE-1:0] : data_q;
    abort_d = (state_q == RECV && !i_dv) || (abort_q && !i_clr);
    ovf_d   = (done && dv_q && !i_ready) || (ovf_q && !i_clr);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
    end
  end
`ifdef S2P_PARITY_EN
  logic perr_q;
  // XOR over data plus parity bit is 1 exactly when even parity is violated.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) perr_q <= 1'b0;
    else          perr_q <= load ? ^sr_d : perr_q;
  end
  assign o_perr = perr_q;
`else
  assign o_perr = 1'b0;
`endif
  assign o_data  = data_q;
  assign o_dv    = dv_q;
  assign o_abort = abort_q;
  assign o_ovf   = ovf_q;
endmodule

// File: tb/tb_s2p.sv
// tb_s2p: scoreboard bench for s2p with directed frames and hand-computed words
module tb_s2p;
`ifdef S2P_PARITY_EN
  localparam int FLEN = 8;
  localparam bit PAR = 1'b1;
`else
  localparam int FLEN = 7;
  localparam bit PAR = 1'b0;
`endif
  typedef struct packed { logic [6:0] d; logic p; } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, din = 1'b0, dv = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [6:0] o_data;
  logic o_dv, o_abort, o_ovf, o_perr;
  int total = 0, bad = 0;
  exp_t sb[$];
  s2p #(.BUFFER_SIZE(7)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_dv(dv), .i_ready(ready), .i_clr(clr),
    .o_data(o_data), .o_dv(o_dv), .o_abort(o_abort), .o_ovf(o_ovf), .o_perr(o_perr)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [6:0] w, input logic p, input int lo, input int hi);
    logic [7:0] f;
    f = {p, w};
    for (int i = lo; i < hi; i++) begin
      din = f[i];
      dv = 1'b1;
      cyc();
    end
  endtask
  task automatic expect_word(input logic [6:0] w, input logic p);
    exp_t e;
    e.d = w;
    e.p = PAR ? (p ^ (^w)) : 1'b0;
    sb.push_back(e);
  endtask
  always @(negedge clk) begin
    if (rst_n && o_dv && ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected act=%0h", o_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (o_data !== e.d || o_perr !== e.p) begin
          bad++;
          $display("FAIL mon_word act=%0h/%0b exp=%0h/%0b", o_data, o_perr, e.d, e.p);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    chk("rst_data", o_data, 0);
    chk("rst_dv", o_dv, 0);
    chk("rst_abort", o_abort, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_perr", o_perr, 0);
    #6 rst_n = 1'b1;
    cyc();
    // single word, accepted immediately: o_dv high for exactly one cycle
    ready = 1'b1;
    expect_word(7'h4B, 1'b0);
    drive(7'h4B, 1'b0, 0, FLEN);
    dv = 1'b0;
    chk("t1_dv", o_dv, 1);
    chk("t1_data", o_data, 7'h4B);
    cyc();
    chk("t1_dv_drop", o_dv, 0);
    chk("t1_abort", o_abort, 0);
    chk("t1_ovf", o_ovf, 0);
    // back-to-back with stall: second word dropped, overflow flagged
    ready = 1'b0;
    expect_word(7'h4B, 1'b0);
    drive(7'h4B, 1'b0, 0, FLEN);
    chk("t2_dv_first", o_dv, 1);
    drive(7'h12, 1'b0, 0, FLEN);
    dv = 1'b0;
    chk("t2_ovf", o_ovf, 1);
    chk("t2_held", o_data, 7'h4B);
    chk("t2_dv", o_dv, 1);
    ready = 1'b1;
    cyc();
    chk("t2_dv_acc", o_dv, 0);
    chk("t2_ovf_sticky", o_ovf, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t2_ovf_clr", o_ovf, 0);
    // abort after 3 bits, then a full 7'h7F frame
    drive(7'h7F, 1'b1, 0, 3);
    dv = 1'b0;
    cyc();
    chk("t3_abort", o_abort, 1);
    chk("t3_no_word", o_dv, 0);
    expect_word(7'h7F, 1'b1);
    drive(7'h7F, 1'b1, 0, FLEN);
    dv = 1'b0;
    chk("t3_data", o_data, 7'h7F);
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t3_abort_clr", o_abort, 0);
    // accept and completion on the same edge
    ready = 1'b0;
    expect_word(7'h01, 1'b1);
    drive(7'h01, 1'b1, 0, FLEN);
    dv = 1'b0;
    cyc();
    chk("t4_hold", o_data, 7'h01);
    expect_word(7'h55, 1'b0);
    drive(7'h55, 1'b0, 0, FLEN - 1);
    ready = 1'b1;
    drive(7'h55, 1'b0, FLEN - 1, FLEN);
    dv = 1'b0;
    chk("t4_dv", o_dv, 1);
    chk("t4_data", o_data, 7'h55);
    chk("t4_ovf", o_ovf, 0);
    cyc();
    chk("t4_dv_drop", o_dv, 0);
    // async reset mid-frame
    drive(7'h3C, 1'b0, 0, 4);
    dv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_data", o_data, 0);
    chk("t5_dv", o_dv, 0);
    chk("t5_abort", o_abort, 0);
    #3 rst_n = 1'b1;
    cyc();
    expect_word(7'h3C, 1'b0);
    drive(7'h3C, 1'b0, 0, FLEN);
    dv = 1'b0;
    chk("t5_clean", o_data, 7'h3C);
    chk("t5_abort_after", o_abort, 0);
    cyc();
`ifdef S2P_PARITY_EN
    expect_word(7'h4B, 1'b0);
    drive(7'h4B, 1'b0, 0, FLEN);
    dv = 1'b0;
    chk("p_good_perr", o_perr, 0);
    cyc();
    expect_word(7'h4B, 1'b1);
    drive(7'h4B, 1'b1, 0, FLEN);
    dv = 1'b0;
    chk("p_bad_data", o_data, 7'h4B);
    chk("p_bad_perr", o_perr, 1);
    cyc();
`endif
    cyc();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
